karatsuba_seq_ctrl: RTL
=======================

Name: karatsuba_seq_ctrl

Overview:
- Multi-cycle sequencer for carry-less (GF(2)) Karatsuba multiplication.
- Time-shares one half-width carry-less multiplier core across the three Karatsuba partial products: lo×lo, hi×hi, mid×mid.
- Recombines the partial products with XOR and shifts, then presents the 2N-bit result on a valid/ready output.
- Sits between an operand producer and a result consumer in the GF(2) arithmetic datapath. It trades area (one core instead of three) for throughput.

Parameters:
- N, 16, operand width; must be even and ≥4 (elaboration error otherwise).
- H, N/2, half width; derived, not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  controller can accept operands
- a  input  N  operand A (polynomial, bit i = coeff of x^i)
- b  input  N  operand B
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out  output  2N  carry-less product A·B over GF(2)
- busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset:
  - One clock domain.
  - rst_n sampled on the rising clk edge only. While low: state←IDLE, out←0, out_valid←0, all internal registers←0.
  - Reset mid-operation aborts the operation silently. No output is produced for an aborted operation.
- Handshakes:
  - in_ready = (state==IDLE), combinational from state only.
  - Accept on the edge where in_valid && in_ready. Capture a, b into a_r, b_r.
  - a and b are don't-care after acceptance.
- FSM states: IDLE → LO → HI → MID → DONE → IDLE.
  - IDLE: wait for accept; on accept → LO.
  - LO: core inputs a_r[H-1:0], b_r[H-1:0]. On edge: p_lo←core_out; → HI.
  - HI: core inputs a_r[N-1:H], b_r[N-1:H]. On edge: p_hi←core_out; → MID.
  - MID: core inputs a_r[N-1:H]^a_r[H-1:0], b_r[N-1:H]^b_r[H-1:0]. On edge: out←(p_hi<<N) ^ p_lo ^ ((core_out^p_lo^p_hi)<<H), computed at 2N width with zero-extension; out_valid←1; → DONE.
  - DONE: hold out and out_valid stable. On out_valid && out_ready: out_valid←0; → IDLE. out keeps its last value.
- Core input mux: drive zeros in IDLE and DONE.
- Latency: 4 edges from accept edge to out_valid high. Minimum initiation interval is 5 cycles (back-to-back with out_ready=1).
- Backpressure: out_ready low holds DONE indefinitely. in_ready stays low; no operand is lost or overwritten.
- Simultaneous in_valid and out_ready in DONE: the result is consumed; the new operand is not accepted until the next cycle (in IDLE).
- All arithmetic is XOR-only; no carries. Partial products are 2H=N bits wide.
- Encode unused state encodings to return to IDLE on the next edge with out_valid←0.

Decomposition:
- Shared package: state enum (IDLE, LO, HI, MID, DONE) as localparams, and the function computing the recombination expression.
- One sub-module, gf2_clmul_core #(W): purely combinational W×W → 2W carry-less multiplier, instantiated once with W=H.
- The controller, operand registers, product registers and output register live in karatsuba_seq_ctrl.

Test Plan (N=16):
- a=0x0003, b=0x0003, out_ready=1 → out=0x00000005; out_valid exactly 4 edges after accept, high for 1 cycle.
- a=0x00FF, b=0x00FF → out=0x00005555. a=0xFFFF, b=0x0001 → out=0x0000FFFF.
- a=0x8000, b=0x8000 → out=0x40000000 (hi-half path, shift by N). a=0x8001, b=0x8001 → out=0x40000001 (cancellation through the mid term).
- Backpressure: result pending, out_ready=0 for 10 cycles while in_valid=1 with new operands → out stable, in_ready=0 throughout. Then out_ready=1 → one handshake, next operand accepted the following cycle.
- Reset: assert rst_n=0 during HI → next edge: state IDLE, out_valid=0, out=0, in_ready=1. A following op 0x0003×0x0005 yields out=0x0000000F with no stale result.
- Random: 1000 random operand pairs with random out_ready stalls, compared against a bit-serial GF(2) reference model. Check busy==!in_ready every cycle.

Source files
------------

// File: rtl/karatsuba_seq_ctrl_pkg.sv
// Shared definitions for the sequential carry-less Karatsuba multiplier.
//
// Contents:
//   MAX_N      - widest operand the recombination helper supports
//   state_t    - controller states IDLE -> LO -> HI -> MID -> DONE
//   recombine  - XOR/shift merge of the three half-width partial products
package karatsuba_seq_ctrl_pkg;

  localparam int MAX_N = 64;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LO   = 3'd1,
    HI   = 3'd2,
    MID  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Karatsuba over GF(2): the middle term is mid*mid with lo and hi
  // cancelled out by XOR, because there are no carries to undo.
  // Partial products arrive zero-extended to MAX_N bits.
  // n is the full operand width, so the middle term shifts by n/2.
  function automatic logic [2*MAX_N-1:0] recombine(
    input logic [MAX_N-1:0] p_lo,
    input logic [MAX_N-1:0] p_hi,
    input logic [MAX_N-1:0] p_mid,
    input int               n
  );
    logic [2*MAX_N-1:0] lo_x;
    logic [2*MAX_N-1:0] hi_x;
    logic [2*MAX_N-1:0] mid_x;
    lo_x  = {{MAX_N{1'b0}}, p_lo};
    hi_x  = {{MAX_N{1'b0}}, p_hi};
    mid_x = {{MAX_N{1'b0}}, p_mid ^ p_lo ^ p_hi};
    return (hi_x << n) ^ lo_x ^ (mid_x << (n / 2));
  endfunction

endpackage

// File: rtl/karatsuba_seq_ctrl_clmul.sv
// Purely combinational W x W carry-less (GF(2)) multiplier.
//
// Ports:
//   a, b : W-bit polynomials, bit i = coefficient of x^i
//   p    : 2W-bit product a*b over GF(2)
module gf2_clmul_core #(
  parameter int W = 8
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);

  always_comb begin
    p = '0;
    for (int i = 0; i < W; i++) begin
      if (b[i]) begin
        p = p ^ ({{W{1'b0}}, a} << i);
      end
    end
  end

endmodule

// File: rtl/karatsuba_seq_ctrl.sv
// Multi-cycle carry-less Karatsuba multiplier. One half-width core is
// reused for the lo*lo, hi*hi and mid*mid partial products, and the
// products are then merged into a 2N-bit result.
//
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid / in_ready  : operand handshake (in_ready only in IDLE)
//   a, b                 : N-bit operands
//   out_valid / out_ready: result handshake
//   out                  : 2N-bit carry-less product, held after consumption
//   busy                 : high whenever the controller is not IDLE
module karatsuba_seq_ctrl
  import karatsuba_seq_ctrl_pkg::*;
#(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out,
  output logic           busy
);

  localparam int H = N / 2;

  if ((N % 2) != 0 || N < 4 || N > MAX_N) begin : g_bad_n
    $error("karatsuba_seq_ctrl: N must be even, >= 4 and <= MAX_N");
  end

  state_t         state;
  logic [N-1:0]   a_r;
  logic [N-1:0]   b_r;
  logic [N-1:0]   p_lo;
  logic [N-1:0]   p_hi;
  logic [H-1:0]   core_a;
  logic [H-1:0]   core_b;
  logic [2*H-1:0] core_p;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Idle and done states feed zeros so the core does not toggle needlessly.
  always_comb begin
    core_a = '0;
    core_b = '0;
    case (state)
      LO: begin
        core_a = a_r[H-1:0];
        core_b = b_r[H-1:0];
      end
      HI: begin
        core_a = a_r[N-1:H];
        core_b = b_r[N-1:H];
      end
      MID: begin
        core_a = a_r[N-1:H] ^ a_r[H-1:0];
        core_b = b_r[N-1:H] ^ b_r[H-1:0];
      end
      default: begin
        core_a = '0;
        core_b = '0;
      end
    endcase
  end

  gf2_clmul_core #(.W(H)) u_core (
    .a (core_a),
    .b (core_b),
    .p (core_p)
  );

  // The mid product is not stored: it is folded into the result on the
  // same edge it is produced, which saves one N-bit register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_r       <= '0;
      b_r       <= '0;
      p_lo      <= '0;
      p_hi      <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r   <= a;
            b_r   <= b;
            state <= LO;
          end
        end
        LO: begin
          p_lo  <= core_p;
          state <= HI;
        end
        HI: begin
          p_hi  <= core_p;
          state <= MID;
        end
        MID: begin
          out       <= (2*N)'(recombine(MAX_N'(p_lo), MAX_N'(p_hi),
                                        MAX_N'(core_p), N));
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
